load_store_unit: RTL and testbench

- Sits between the MEM pipeline stage and the word-addressed data memory.
- Converts byte-addressed MIPS load/store requests (lb/lbu/lh/lhu/lw/sb/sh/sw) into word accesses on the memory's mem_read/mem_write/address/write_data/mem_data interface.
- The memory has no byte enables, so sb/sh are performed as read-modify-write.
- Also performs sign/zero extension, alignment checks and range checks.

---
 rtl/lsu_pkg.sv | 47 ++++
 rtl/lsu_align.sv | 63 ++++++
 rtl/load_store_unit.sv | 141 ++++++++++++++
 tb/tb_load_store_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: MIPS memory op codes, FSM state
// encoding and small op-classification helpers.
package lsu_pkg;

    // Memory op codes as presented by the MEM stage.
    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LH  = 3'd1,
        OP_LW  = 3'd2,
        OP_LBU = 3'd3,
        OP_LHU = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } lsu_op_e;

    // Request sequencing states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,   // waiting for a request
        RD   = 3'd1,   // read strobe to memory
        CAP  = 3'd2,   // memory read data valid
        WR   = 3'd3,   // write strobe to memory
        ERR  = 3'd4    // rejected request, error response
    } lsu_state_e;

    // Loads return data in CAP.
    function automatic logic is_load(input lsu_op_e op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    // Any store ends with a write strobe.
    function automatic logic is_store(input lsu_op_e op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    // Sub-word stores need a read-modify-write because memory has no byte enables.
    function automatic logic is_rmw_store(input lsu_op_e op);
        return op inside {OP_SB, OP_SH};
    endfunction

    // Every 3-bit code is assigned, so this only guards against X/future
    // encodings; it keeps the error path explicit in the top level.
    function automatic logic is_defined_op(input logic [2:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic for the load/store unit: load extraction with sign/zero
// extension, sub-word merge for read-modify-write stores, and the alignment
// check. Purely combinational; lanes are little-endian.
module lsu_align
    import lsu_pkg::*;
(
    input  lsu_op_e     op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word,
    output logic        misalign
);

    logic [4:0]  byte_shift;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_shift = {addr_lo, 3'b000};

    // Select the addressed lane and extend it to a full word.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case leaves it unassigned and infers a latch.
        load_data = '0;
        byte_v    = word[byte_shift +: 8];
        half_v    = addr_lo[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   load_data = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  load_data = {24'h000000, byte_v};
            OP_LH:   load_data = {{16{half_v[15]}}, half_v};
            OP_LHU:  load_data = {16'h0000, half_v};
            OP_LW:   load_data = word;
            default: load_data = '0;
        endcase
    end

    // Replace the target lane(s) of the read word with the store data.
    always_comb begin
        store_word = word;
        case (op)
            OP_SB: store_word[byte_shift +: 8] = wdata[7:0];
            OP_SH: begin
                if (addr_lo[1]) store_word[31:16] = wdata[15:0];
                else            store_word[15:0]  = wdata[15:0];
            end
            OP_SW:   store_word = wdata;
            default: store_word = word;
        endcase
    end

    // Halfword ops need an even address, word ops a 4-byte-aligned address.
    always_comb begin
        misalign = 1'b0;
        case (op)
            OP_LH, OP_LHU, OP_SH: misalign = addr_lo[0];
            OP_LW, OP_SW:         misalign = |addr_lo;
            default:              misalign = 1'b0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a word-addressed data memory.
// Turns byte-addressed lb/lbu/lh/lhu/lw/sb/sh/sw requests into word
// accesses; sub-word stores are done as read-modify-write. One request is
// in flight at a time; requests are only accepted in IDLE.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32,     // only 32 is supported
    parameter int DEPTH = 1024    // memory size in words
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    output logic             rsp_err,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             mem_read,
    output logic             mem_write,
    output logic [WIDTH-1:0] mem_address,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);

    lsu_state_e       state, state_nxt;
    lsu_op_e          op_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] data_q;      // store data, then the merged word for sb/sh

    lsu_op_e          align_op;
    logic [1:0]       align_lane;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] merged_word;
    logic             misalign;

    logic             accept;
    logic [WIDTH-1:0] req_word_idx;
    logic             req_err;

    assign accept       = req_valid && (state == IDLE);
    assign req_word_idx = {2'b00, req_addr[WIDTH-1:2]};

    // In IDLE the lane logic checks the incoming request; afterwards it
    // works on the captured request and the returned memory word.
    assign align_op   = (state == IDLE) ? lsu_op_e'(req_op) : op_q;
    assign align_lane = (state == IDLE) ? req_addr[1:0] : addr_q[1:0];

    lsu_align u_align (
        .op         (align_op),
        .addr_lo    (align_lane),
        .word       (mem_rdata),
        .wdata      (data_q),
        .load_data  (load_data),
        .store_word (merged_word),
        .misalign   (misalign)
    );

    // Reject misaligned, out-of-range or unknown requests before any access.
    assign req_err = misalign || (req_word_idx >= DEPTH_W) || !is_defined_op(req_op);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Capture the request on accept; replace store data with the merged word in CAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= OP_LB;
            addr_q <= '0;
            data_q <= '0;
        end else if (accept) begin
            op_q   <= lsu_op_e'(req_op);
            addr_q <= req_addr;
            data_q <= req_wdata;
        end else if (state == CAP && is_rmw_store(op_q)) begin
            data_q <= merged_word;
        end
    end

    // Next-state and output decode; outputs depend on registered state only
    // (plus mem_rdata for the load response in CAP).
    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_err     = 1'b0;
        rsp_rdata   = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;

        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)                        state_nxt = ERR;
                    else if (lsu_op_e'(req_op) == OP_SW) state_nxt = WR;
                    else                                state_nxt = RD;
                end
            end
            RD: begin
                mem_read    = 1'b1;
                mem_address = {2'b00, addr_q[WIDTH-1:2]};
                state_nxt   = CAP;
            end
            CAP: begin
                if (is_load(op_q)) begin
                    rsp_valid = 1'b1;
                    rsp_rdata = load_data;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = WR;
                end
            end
            WR: begin
                mem_write   = 1'b1;
                mem_address = {2'b00, addr_q[WIDTH-1:2]};
                mem_wdata   = data_q;
                rsp_valid   = 1'b1;
                state_nxt   = IDLE;
            end
            ERR: begin
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed table-driven bench for load_store_unit with a word-addressed
// memory model (read data registered one cycle after mem_read).
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.WIDTH(32), .DEPTH(1024)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_err     (rsp_err),
        .rsp_rdata   (rsp_rdata),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // Memory model with a bench-side preload port.
    logic [31:0] tb_mem [0:1023];
    logic        pre_we = 1'b0;
    logic [9:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;

    always @(posedge clk) begin
        if (pre_we)         tb_mem[pre_idx] <= pre_val;
        else if (mem_write) tb_mem[mem_address[9:0]] <= mem_wdata;
        if (mem_read)       mem_rdata <= tb_mem[mem_address[9:0]];
    end

    // Simultaneous read and write strobes must never appear.
    logic overlap_seen = 1'b0;
    always @(negedge clk) if (mem_read && mem_write) overlap_seen = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] val);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = idx; pre_val = val;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    // Results of the last request.
    int          r_lat;
    logic        r_err, r_rd, r_wr;
    logic [31:0] r_rdata, r_addr, r_wval;

    // Issue one request and watch up to 8 cycles for its response.
    task automatic run_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        r_lat = 0; r_err = 1'b0; r_rd = 1'b0; r_wr = 1'b0;
        r_rdata = '0; r_addr = '0; r_wval = '0;
        @(negedge clk);
        req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if ((mem_read || mem_write) && !r_rd && !r_wr) r_addr = mem_address;
            if (mem_read) r_rd = 1'b1;
            if (mem_write) begin
                r_wr   = 1'b1;
                r_wval = mem_wdata;
            end
            if (rsp_valid) begin
                r_lat   = k;
                r_err   = rsp_err;
                r_rdata = rsp_rdata;
                break;
            end
        end
    endtask

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  lat;
        logic        err;
        logic [31:0] rdata;
        logic        rd;
        logic        wr;
        logic [31:0] wval;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] lat, input logic err, input logic [31:0] rdata,
                                input logic rd, input logic wr, input logic [31:0] wval);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.lat = lat; v.err = err;
        v.rdata = rdata; v.rd = rd; v.wr = wr; v.wval = wval;
        return v;
    endfunction

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Starting contents: mem[4]=8899AABB, mem[1023]=00000080. Applied in order.
        vecs[0]  = mk(OP_LB,  32'h11,   32'h0,        2, 0, 32'hFFFFFFAA, 1, 0, 32'h0);
        vecs[1]  = mk(OP_LBU, 32'h11,   32'h0,        2, 0, 32'h000000AA, 1, 0, 32'h0);
        vecs[2]  = mk(OP_LHU, 32'h12,   32'h0,        2, 0, 32'h00008899, 1, 0, 32'h0);
        vecs[3]  = mk(OP_LH,  32'h12,   32'h0,        2, 0, 32'hFFFF8899, 1, 0, 32'h0);
        vecs[4]  = mk(OP_LH,  32'h10,   32'h0,        2, 0, 32'hFFFFAABB, 1, 0, 32'h0);
        vecs[5]  = mk(OP_SB,  32'h12,   32'h12345677, 3, 0, 32'h0,        1, 1, 32'h8877AABB);
        vecs[6]  = mk(OP_SH,  32'h10,   32'h0000CAFE, 3, 0, 32'h0,        1, 1, 32'h8877CAFE);
        vecs[7]  = mk(OP_LW,  32'h10,   32'h0,        2, 0, 32'h8877CAFE, 1, 0, 32'h0);
        vecs[8]  = mk(OP_LBU, 32'h13,   32'h0,        2, 0, 32'h00000088, 1, 0, 32'h0);
        vecs[9]  = mk(OP_SW,  32'h20,   32'hDEADBEEF, 1, 0, 32'h0,        0, 1, 32'hDEADBEEF);
        vecs[10] = mk(OP_LW,  32'h20,   32'h0,        2, 0, 32'hDEADBEEF, 1, 0, 32'h0);
        vecs[11] = mk(OP_LH,  32'h13,   32'h0,        1, 1, 32'h0,        0, 0, 32'h0);
        vecs[12] = mk(OP_LW,  32'h22,   32'h0,        1, 1, 32'h0,        0, 0, 32'h0);
        vecs[13] = mk(OP_SW,  32'h1000, 32'h0,        1, 1, 32'h0,        0, 0, 32'h0);
        vecs[14] = mk(OP_LB,  32'hFFC,  32'h0,        2, 0, 32'hFFFFFF80, 1, 0, 32'h0);
        vecs[15] = mk(OP_SB,  32'hFFF,  32'h0000005A, 3, 0, 32'h0,        1, 1, 32'h5A000080);
        vecs[16] = mk(OP_SH,  32'h11,   32'h0000FFFF, 1, 1, 32'h0,        0, 0, 32'h0);
        vecs[17] = mk(OP_LBU, 32'h1003, 32'h0,        1, 1, 32'h0,        0, 0, 32'h0);

        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        #1;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_err",   {31'b0, rsp_err},   32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_mem_strb",  {30'b0, mem_read, mem_write}, 32'd0);
        check("rst_mem_addr",  mem_address, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        preload(10'd4, 32'h8899AABB);
        preload(10'd1023, 32'h00000080);

        for (int i = 0; i < NVEC; i++) begin
            run_req(vecs[i].op, vecs[i].addr, vecs[i].wdata);
            check($sformatf("v%0d_latency", i), 32'(r_lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_err", i),     {31'b0, r_err}, {31'b0, vecs[i].err});
            check($sformatf("v%0d_rdata", i),   r_rdata, vecs[i].rdata);
            check($sformatf("v%0d_rd_strobe", i), {31'b0, r_rd}, {31'b0, vecs[i].rd});
            check($sformatf("v%0d_wr_strobe", i), {31'b0, r_wr}, {31'b0, vecs[i].wr});
            if (vecs[i].rd || vecs[i].wr)
                check($sformatf("v%0d_mem_addr", i), r_addr, {2'b00, vecs[i].addr[31:2]});
            if (vecs[i].wr)
                check($sformatf("v%0d_mem_wdata", i), r_wval, vecs[i].wval);
        end

        // Back-to-back: sb then lw with req_valid held high throughout.
        preload(10'd0, 32'h11223344);
        @(negedge clk);
        req_op = OP_SB; req_addr = 32'h0; req_wdata = 32'h000000A5; req_valid = 1'b1;
        @(posedge clk);
        #1 req_op = OP_LW; req_wdata = 32'h0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("b2b_ready_low_k%0d", k), {31'b0, req_ready}, 32'd0);
        end
        check("b2b_sb_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check("b2b_sb_write",     {31'b0, mem_write}, 32'd1);
        check("b2b_sb_wdata",     mem_wdata, 32'h112233A5);
        @(negedge clk);
        check("b2b_ready_back",   {31'b0, req_ready}, 32'd1);
        check("b2b_rsp_single",   {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        check("b2b_lw_read",      {31'b0, mem_read}, 32'd1);
        req_valid = 1'b0;
        @(negedge clk);
        check("b2b_lw_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check("b2b_lw_rdata",     rsp_rdata, 32'h112233A5);
        @(negedge clk);
        check("b2b_idle_ready",   {31'b0, req_ready}, 32'd1);

        // Reset asserted during the CAP cycle of an sb.
        preload(10'd5, 32'h01020304);
        @(negedge clk);
        req_op = OP_SB; req_addr = 32'h14; req_wdata = 32'h000000FF; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rmid_rd_strobe", {31'b0, mem_read}, 32'd1);
        @(negedge clk);
        check("rmid_cap_no_rsp", {31'b0, rsp_valid}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("rmid_req_ready", {31'b0, req_ready}, 32'd1);
        check("rmid_rsp",       {30'b0, rsp_valid, rsp_err}, 32'd0);
        check("rmid_mem_strb",  {30'b0, mem_read, mem_write}, 32'd0);
        check("rmid_mem_addr",  mem_address, 32'h0);
        check("rmid_mem_wdata", mem_wdata, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rmid_no_write_%0d", k), {31'b0, mem_write}, 32'd0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("rmid_after_write_%0d", k), {31'b0, mem_write}, 32'd0);
        end
        check("rmid_after_ready", {31'b0, req_ready}, 32'd1);
        check("rmid_mem_intact",  tb_mem[5], 32'h01020304);
        run_req(OP_LW, 32'h14, 32'h0);
        check("rmid_lw_latency", 32'(r_lat), 32'd2);
        check("rmid_lw_rdata",   r_rdata, 32'h01020304);

        check("no_rd_wr_overlap", {31'b0, overlap_seen}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
